baud_sched: RTL

- Controller that sequences the team's `timer_input` baud counter for the UART.
- Maps a 3-bit baud select onto the timer's FINAL_VALUE divisor and starts, stops and resyncs the timer.
- Applies baud changes only on tick boundaries, so no short or runt tick is ever produced.
- Outputs the 16x oversample tick (`s_tick`) for UART RX/TX and a derived per-bit tick (`bit_tick`).

---
 rtl/baud_pkg.sv | 31 +++
 rtl/timer_input.sv | 26 ++
 rtl/baud_sched.sv | 137 +++++++++++++
 3 files changed

// File: rtl/baud_pkg.sv
// baud_pkg: shared constants for the UART baud scheduler.
// Holds the FSM state codes, the baud-select map, the fixed divisors and the custom-divisor limits.
package baud_pkg;

  localparam int SEL_W = 3;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_RELOAD = 2'd1;
  localparam state_t ST_RUN    = 2'd2;
  localparam state_t ST_PEND   = 2'd3;

  // Timer FINAL_VALUE per select: 9600, 19200, 38400, 57600, 115200 baud at 100 MHz, 16x.
  localparam int NUM_FIXED = 5;
  localparam int DIV_TABLE [NUM_FIXED] = '{650, 324, 162, 108, 53};

  localparam logic [SEL_W-1:0] SEL_CUSTOM = 3'd7;
  localparam int MIN_CUSTOM_DIV = 4;

  function automatic logic fixed_valid(input logic [SEL_W-1:0] sel);
    return int'(sel) < NUM_FIXED;
  endfunction

  function automatic int fixed_div(input logic [SEL_W-1:0] sel);
    int d;
    d = 0;
    if (int'(sel) < NUM_FIXED) d = DIV_TABLE[sel];
    return d;
  endfunction

endpackage

// File: rtl/timer_input.sv
// timer_input: modulo counter running 0..final_value while enabled.
// done is high in the cycle the count equals final_value; the count then wraps to 0.
module timer_input #(
  parameter int BITS = 11
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [BITS-1:0] final_value,
  output logic            done
);

  logic [BITS-1:0] q;

  assign done = (q == final_value);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= '0;
    end else if (enable) begin
      if (done) q <= '0;
      else      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/baud_sched.sv
// baud_sched: sequences timer_input to produce the UART oversample tick and the per-bit tick.
// Optional macro BAUD_CUSTOM_EN makes select 7 a custom divisor captured from cfg_div.
module baud_sched
  import baud_pkg::*;
#(
  parameter int BITS = 11,
  parameter int OSR  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             resync,
  input  logic             cfg_valid,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [BITS-1:0]  cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             s_tick,
  output logic             bit_tick,
  output logic             active,
  output logic [SEL_W-1:0] cur_sel
);

  localparam int OSR_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [OSR_W-1:0] OSR_LAST = OSR_W'(OSR - 1);
  localparam logic [BITS-1:0] RESET_DIV = BITS'(DIV_TABLE[0]);

  // cfg handshake: a request transfers in any cycle where cfg_valid and cfg_ready are both high;
  // cfg_ready depends only on state and reset_n, never on cfg_valid.
  state_t           state;
  logic [BITS-1:0]  divisor;
  logic [BITS-1:0]  cur_div;
  logic [BITS-1:0]  pend_div;
  logic [SEL_W-1:0] pend_sel;
  logic [OSR_W-1:0] osr_cnt;
  logic [BITS-1:0]  req_div;
  logic             req_ok;
  logic             accept;
  logic             acc_ok;
  logic             acc_bad;
  logic             idle_like;
  logic             timer_rst_n;
  logic             timer_done;

`ifdef BAUD_CUSTOM_EN
  always_comb begin
    req_ok  = fixed_valid(cfg_sel);
    req_div = BITS'(fixed_div(cfg_sel));
    if (cfg_sel == SEL_CUSTOM) begin
      req_ok  = (cfg_div >= BITS'(MIN_CUSTOM_DIV));
      req_div = cfg_div;
    end
  end
`else
  logic unused_div;
  assign unused_div = ^cfg_div;

  always_comb begin
    req_ok  = fixed_valid(cfg_sel);
    req_div = BITS'(fixed_div(cfg_sel));
  end
`endif

  assign active      = (state == ST_RUN) || (state == ST_PEND);
  assign idle_like   = (state == ST_IDLE) || (state == ST_RELOAD);
  assign cfg_ready   = reset_n && ((state == ST_IDLE) || (state == ST_RUN));
  assign accept      = cfg_valid && cfg_ready;
  assign acc_ok      = accept && req_ok;
  assign acc_bad     = accept && !req_ok;
  assign timer_rst_n = reset_n && !idle_like;

  timer_input #(.BITS(BITS)) u_timer (
    .clk         (clk),
    .reset_n     (timer_rst_n),
    .enable      (active),
    .final_value (divisor),
    .done        (timer_done)
  );

  assign s_tick   = timer_done && active;
  assign bit_tick = s_tick && (osr_cnt == OSR_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cur_sel  <= '0;
      cur_div  <= RESET_DIV;
      divisor  <= RESET_DIV;
      pend_sel <= '0;
      pend_div <= RESET_DIV;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= acc_bad;
      case (state)
        ST_IDLE: begin
          if (acc_ok) begin
            cur_sel <= cfg_sel;
            cur_div <= req_div;
          end
          if (run) state <= ST_RELOAD;
        end
        ST_RELOAD: begin
          divisor <= cur_div;
          state   <= ST_RUN;
        end
        ST_RUN: begin
          // Stop and resync bypass the tick boundary, so a request arriving with them lands at once.
          if (!run || resync) begin
            if (acc_ok) begin
              cur_sel <= cfg_sel;
              cur_div <= req_div;
            end
            state <= run ? ST_RELOAD : ST_IDLE;
          end else if (acc_ok) begin
            pend_sel <= cfg_sel;
            pend_div <= req_div;
            state    <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (!run || s_tick) begin
            cur_sel <= pend_sel;
            cur_div <= pend_div;
            state   <= run ? ST_RELOAD : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || idle_like) osr_cnt <= '0;
    else if (s_tick)           osr_cnt <= osr_cnt + 1'b1;
  end

endmodule
